// File: rtl/ps2_kbd_rx_fifo_if.sv
// ps2_kbd_rx_fifo_if - key-event stream between the PS/2 receiver and its consumer.
// master: receiver side (drives event data/valid); slave: consumer side (drives ready).
interface ps2_kbd_rx_fifo_if;
    logic [9:0] oEVT_DATA;   // {ext, brk, code[7:0]}
    logic       oEVT_VALID;
    logic       iEVT_READY;

    modport master (output oEVT_DATA, output oEVT_VALID, input iEVT_READY);
    modport slave  (input oEVT_DATA, input oEVT_VALID, output iEVT_READY);
endinterface

// File: rtl/ps2_kbd_rx_fifo.sv
// ps2_kbd_rx_fifo - PS/2 keyboard receiver with glitch filter, frame checking,
// inter-edge timeout, E0/F0 prefix decoding and a first-word fall-through event FIFO.
// Optional feature macro: PS2_DIGIT_MAP_EN adds oDIGIT/oDIGIT_STB digit decoding.
module ps2_kbd_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              iCLK_50,
    input  logic              iRST_N,
    input  logic              iEN,
    input  logic              PS2_KBCLK,
    input  logic              PS2_KBDAT,
    ps2_kbd_rx_fifo_if.master evt,
    output logic              oFRAME_ERR,
    output logic              oOVERFLOW,
    output logic              oBUSY
`ifdef PS2_DIGIT_MAP_EN
    ,
    output logic [3:0]        oDIGIT,
    output logic              oDIGIT_STB
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic [1:0]            kclk_sync, kdat_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk, filt_clk_d;
    logic                  fall, kdat;

    // Synchronise both PS/2 lines and debounce the clock before edge detection.
    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            kclk_sync  <= 2'b11;
            kdat_sync  <= 2'b11;
            filt_sr    <= '1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            kclk_sync  <= {kclk_sync[0], PS2_KBCLK};
            kdat_sync  <= {kdat_sync[0], PS2_KBDAT};
            filt_sr    <= {filt_sr[FILTER_LEN-2:0], kclk_sync[1]};
            if (&filt_sr)
                filt_clk <= 1'b1;
            else if (~|filt_sr)
                filt_clk <= 1'b0;
            filt_clk_d <= filt_clk;
        end
    end

    assign fall = filt_clk_d & ~filt_clk;
    assign kdat = kdat_sync[1];

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;        // bits arrive LSB-first at the top and move down
    logic [TW-1:0] tmo_cnt;
    logic          frame_ok, ext_flag, brk_flag;
    logic          frame_good;   // parity/stop verdict evaluated on the stop-bit fall
    logic [7:0]    rx_byte;
    logic          push;

    // On the stop fall, shreg[9:1] holds d0..d7,parity and kdat is the stop bit.
    assign frame_good = (^shreg[9:1]) & kdat;
    assign rx_byte    = shreg[7:0];
    assign push       = (state == CHECK) && frame_ok &&
                        (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

    // Frame FSM: start detection, bit shifting, timeout, verdict and prefix tracking.
    // NOTE: all state here uses <= so every branch sees the pre-edge values.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 10'd0;
            tmo_cnt    <= '0;
            frame_ok   <= 1'b0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            oFRAME_ERR <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            oFRAME_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (fall && iEN && !kdat) begin
                        state   <= SHIFT;
                        bit_cnt <= 4'd0;
                        oBUSY   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        shreg   <= {kdat, shreg[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            state      <= CHECK;
                            oBUSY      <= 1'b0;
                            frame_ok   <= frame_good;
                            oFRAME_ERR <= ~frame_good;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state      <= IDLE;
                        oBUSY      <= 1'b0;
                        oFRAME_ERR <= 1'b1;
                        ext_flag   <= 1'b0;
                        brk_flag   <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                CHECK: begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                    if (!frame_ok || (rx_byte != 8'hE0 && rx_byte != 8'hF0)) begin
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end else if (rx_byte == 8'hE0) begin
                        ext_flag <= 1'b1;
                    end else begin
                        brk_flag <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [9:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = evt.oEVT_VALID & evt.iEVT_READY;
    assign wr_en = push & (~full | pop);

    assign evt.oEVT_VALID = ~empty;
    assign evt.oEVT_DATA  = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];

    // FIFO storage write.
    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge iCLK_50) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {ext_flag, brk_flag, rx_byte};
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            oOVERFLOW <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop)
                oOVERFLOW <= 1'b1;
        end
    end

`ifdef PS2_DIGIT_MAP_EN
    logic       shift_held;
    logic       dig_hit;
    logic [3:0] dig_val;

    // Map the byte being completed (shreg[8:1] on the stop fall) to a digit or #/*.
    // NOTE: defaults first so no path leaves dig_hit/dig_val unassigned (no latch).
    always_comb begin
        dig_hit = 1'b0;
        dig_val = 4'd0;
        case (shreg[8:1])
            8'h45: begin dig_hit = ~shift_held; dig_val = 4'd0; end
            8'h16: begin dig_hit = ~shift_held; dig_val = 4'd1; end
            8'h1E: begin dig_hit = ~shift_held; dig_val = 4'd2; end
            8'h26: begin dig_hit = 1'b1; dig_val = shift_held ? 4'hA : 4'd3; end
            8'h25: begin dig_hit = ~shift_held; dig_val = 4'd4; end
            8'h2E: begin dig_hit = ~shift_held; dig_val = 4'd5; end
            8'h36: begin dig_hit = ~shift_held; dig_val = 4'd6; end
            8'h3D: begin dig_hit = ~shift_held; dig_val = 4'd7; end
            8'h3E: begin dig_hit = 1'b1; dig_val = shift_held ? 4'hB : 4'd8; end
            8'h46: begin dig_hit = ~shift_held; dig_val = 4'd9; end
            default: ;
        endcase
    end

    // Left-shift tracking and digit strobe, registered so the strobe lands in the push cycle.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            shift_held <= 1'b0;
            oDIGIT     <= 4'd0;
            oDIGIT_STB <= 1'b0;
        end else begin
            oDIGIT_STB <= 1'b0;
            if (push && rx_byte == 8'h12)
                shift_held <= ~brk_flag;
            if (state == SHIFT && fall && bit_cnt == 4'd9 && frame_good &&
                !ext_flag && !brk_flag && dig_hit) begin
                oDIGIT     <= dig_val;
                oDIGIT_STB <= 1'b1;
            end
        end
    end
`endif

endmodule
